pe_acc_pipe: RTL and testbench



---
 rtl/pe_acc_pkg.sv | 41 ++++
 rtl/pe_acc_pipe_add_stage.sv | 45 ++++
 rtl/pe_acc_pipe.sv | 152 +++++++++++++++
 tb/tb_pe_acc_pipe.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pe_acc_pkg.sv
// Shared constants and helpers for the pipelined PE reduction accumulator.
package pe_acc_pkg;

  localparam int BEAT_W    = 16;
  localparam int SAT_MAX_W = 128;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Saturation bounds for a signed field of out_w bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_hi(input int out_w);
    return (128'sd1 <<< (out_w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
      input logic signed [SAT_MAX_W-1:0] value, input int in_w, input int out_w);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = sat_hi(out_w);
    lo = -hi - 128'sd1;
    if (in_w <= out_w) return value;
    else if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

  function automatic logic sat_clip(
      input logic signed [SAT_MAX_W-1:0] value, input int in_w, input int out_w);
    logic signed [SAT_MAX_W-1:0] hi;
    hi = sat_hi(out_w);
    if (in_w <= out_w) return 1'b0;
    else return (value > hi) || (value < (-hi - 128'sd1));
  endfunction

endpackage

// File: rtl/pe_acc_pipe_add_stage.sv
// One registered level of the adder tree: N signed inputs reduce to N/2 sums one bit wider.
module pe_add_stage
  import pe_acc_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic                     i_last,
  input  logic [N*W-1:0]           i_data,
  output logic                     o_valid,
  output logic                     o_last,
  output logic [(N/2)*(W+1)-1:0]   o_data
);

  logic [(N/2)*(W+1)-1:0] r_data;
  logic                   r_valid;
  logic                   r_last;

  // Pairwise sign-extended sums; payload only moves with a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= {((N/2)*(W+1)){1'b0}};
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_last <= i_last;
        for (int k = 0; k < N/2; k++) begin
          r_data[k*(W+1) +: W+1] <= {i_data[2*k*W + W-1], i_data[2*k*W +: W]}
                                  + {i_data[(2*k+2)*W - 1], i_data[(2*k+1)*W +: W]};
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/pe_acc_pipe.sv
// Pipelined lane-reduction accumulator: input register, log2(LANES) tree levels, then a
// group accumulator that emits one result per last-tagged beat under valid/ready control.
module pe_acc_pipe
  import pe_acc_pkg::*;
#(
  parameter int LANES = 32,
  parameter int PW    = 32,
  parameter int ACC_W = 48,
  parameter int OUT_W = 32,
  parameter int SAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*PW-1:0]   in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_sat,
  output logic [BEAT_W-1:0]     out_beats
);

  localparam int L = clog2(LANES);

  // Bit offset of tree level lvl inside the flat bus (level 0 is the input register).
  function automatic int lvl_off(input int lvl);
    int s;
    s = 0;
    for (int k = 0; k < lvl; k++) s += (LANES >> k) * (PW + k);
    return s;
  endfunction

  localparam int BUS_W = lvl_off(L + 1);

  logic                  w_adv;
  logic [BUS_W-1:0]      w_bus;
  logic [L:0]            w_vld;
  logic [L:0]            w_lst;
  logic [PW+L-1:0]       w_root;

  logic [LANES*PW-1:0]   r_s0_data;
  logic                  r_s0_valid;
  logic                  r_s0_last;

  logic [ACC_W-1:0]      r_acc;
  logic [BEAT_W-1:0]     r_beats;
  logic                  r_grp_open;
  logic                  r_out_valid;
  logic [OUT_W-1:0]      r_out_data;
  logic                  r_out_sat;
  logic [BEAT_W-1:0]     r_out_beats;

  logic [ACC_W-1:0]      w_acc_base;
  logic [ACC_W-1:0]      w_acc_next;
  logic [BEAT_W-1:0]     w_beats_base;
  logic [BEAT_W-1:0]     w_beats_next;
  logic [OUT_W-1:0]      w_out_next;
  logic                  w_clip_next;

  assign w_adv    = !(r_out_valid && !out_ready);
  assign in_ready = w_adv;

  // Input register S0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s0_data  <= {(LANES*PW){1'b0}};
    end else if (w_adv) begin
      r_s0_valid <= in_valid;
      if (in_valid) begin
        r_s0_last <= in_last;
        r_s0_data <= in_data;
      end
    end
  end

  assign w_bus[0 +: LANES*PW] = r_s0_data;
  assign w_vld[0]             = r_s0_valid;
  assign w_lst[0]             = r_s0_last;

  for (genvar i = 1; i <= L; i++) begin : g_lvl
    localparam int NI     = LANES >> (i - 1);
    localparam int WI     = PW + i - 1;
    localparam int OFF_I  = lvl_off(i - 1);
    localparam int OFF_O  = lvl_off(i);
    pe_add_stage #(.N(NI), .W(WI)) u_add (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_valid (w_vld[i-1]),
      .i_last  (w_lst[i-1]),
      .i_data  (w_bus[OFF_I +: NI*WI]),
      .o_valid (w_vld[i]),
      .o_last  (w_lst[i]),
      .o_data  (w_bus[OFF_O +: (NI/2)*(WI+1)])
    );
  end

  assign w_root = w_bus[lvl_off(L) +: PW+L];

  // Next accumulator, beat count and formatted result for the beat leaving the root.
  always_comb begin
    w_acc_base   = r_grp_open ? r_acc : {ACC_W{1'b0}};
    w_acc_next   = w_acc_base + ACC_W'($signed(w_root));
    w_beats_base = r_grp_open ? r_beats : {BEAT_W{1'b0}};
    w_beats_next = (w_beats_base == {BEAT_W{1'b1}}) ? w_beats_base
                 : w_beats_base + {{(BEAT_W-1){1'b0}}, 1'b1};
    if (SAT != 0) begin
      w_out_next  = OUT_W'(sat_signed(SAT_MAX_W'($signed(w_acc_next)), ACC_W, OUT_W));
      w_clip_next = sat_clip(SAT_MAX_W'($signed(w_acc_next)), ACC_W, OUT_W);
    end else begin
      w_out_next  = w_acc_next[OUT_W-1:0];
      w_clip_next = 1'b0;
    end
  end

  // Accumulator stage SA; result registers only change when a new result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= {ACC_W{1'b0}};
      r_beats     <= {BEAT_W{1'b0}};
      r_grp_open  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= {OUT_W{1'b0}};
      r_out_sat   <= 1'b0;
      r_out_beats <= {BEAT_W{1'b0}};
    end else if (w_adv) begin
      if (w_vld[L]) begin
        r_acc      <= w_acc_next;
        r_beats    <= w_beats_next;
        r_grp_open <= !w_lst[L];
      end
      if (w_vld[L] && w_lst[L]) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_out_next;
        r_out_sat   <= w_clip_next;
        r_out_beats <= w_beats_next;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_beats = r_out_beats;

endmodule

// File: tb/tb_pe_acc_pipe.sv
// Directed bench for pe_acc_pipe: one truncating and one saturating instance share stimulus.
module tb_pe_acc_pipe;

  localparam int LANES = 32;
  localparam int PW    = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_last;
  logic [LANES*PW-1:0]  in_data;
  logic                 out_ready;

  logic        in_ready0, out_valid0, out_sat0;
  logic [31:0] out_data0;
  logic [15:0] out_beats0;
  logic        in_ready1, out_valid1, out_sat1;
  logic [31:0] out_data1;
  logic [15:0] out_beats1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pe_acc_pipe #(.LANES(LANES), .PW(PW), .ACC_W(48), .OUT_W(32), .SAT(0)) u_dut_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_sat(out_sat0), .out_beats(out_beats0)
  );

  pe_acc_pipe #(.LANES(LANES), .PW(PW), .ACC_W(48), .OUT_W(32), .SAT(1)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_sat(out_sat1), .out_beats(out_beats1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] v, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    in_data  = {LANES{v}};
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Edges elapsed after the accepting edge until out_valid rises (20 means never).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int k_send;
    int k_exp;
    int cyc;
    logic        stalled;
    logic [31:0] hold;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", out_valid0, 64'd0);
    check("rst_out_data",  out_data0,  64'd0);
    check("rst_out_beats", out_beats0, 64'd0);
    check("rst_out_sat",   out_sat1,   64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready0, 64'd1);

    put(32'd1, 1'b1);
    wait_out(lat);
    check("t1_latency", 64'(lat), 64'd6);
    check("t1_data",    out_data0,  64'd32);
    check("t1_beats",   out_beats0, 64'd1);
    check("t1_sat",     out_sat0,   64'd0);
    check("t1_sat_dut", out_data1,  64'd32);
    tick();
    check("t1_drop", out_valid0, 64'd0);

    put(32'd1, 1'b0);
    put(32'd2, 1'b0);
    put(32'd3, 1'b1);
    wait_out(lat);
    check("t2_latency", 64'(lat), 64'd6);
    check("t2_data",    out_data0,  64'd192);
    check("t2_beats",   out_beats0, 64'd3);
    tick();

    put(32'hFFFF_FFFF, 1'b1);
    wait_out(lat);
    check("t3_data",     out_data0, 64'hFFFF_FFE0);
    check("t3_sat_data", out_data1, 64'hFFFF_FFE0);
    check("t3_sat_flag", out_sat1,  64'd0);
    tick();

    put(32'h7FFF_FFFF, 1'b1);
    wait_out(lat);
    check("t4_trunc_data", out_data0, 64'hFFFF_FFE0);
    check("t4_trunc_flag", out_sat0,  64'd0);
    check("t4_sat_data",   out_data1, 64'h7FFF_FFFF);
    check("t4_sat_flag",   out_sat1,  64'd1);
    check("t4_sat_valid",  out_valid1, 64'd1);
    tick();

    k_send = 1; k_exp = 1; cyc = 0; stalled = 1'b0; hold = 32'd0;
    while (k_exp <= 10 && cyc < 100) begin
      out_ready = !(cyc >= 8 && cyc < 12);
      in_valid  = (k_send <= 10);
      in_last   = 1'b1;
      in_data   = {LANES{k_send[31:0]}};
      #1;
      if (out_valid0 && !out_ready) begin
        check("stall_in_ready", in_ready0, 64'd0);
        check("stall_data", out_data0, 64'(32 * k_exp));
        if (stalled) check("stall_stable", out_data0, 64'(hold));
        hold    = out_data0;
        stalled = 1'b1;
      end
      if (out_valid0 && out_ready) begin
        check("stream_data", out_data0, 64'(32 * k_exp));
        k_exp++;
      end
      if (in_valid && in_ready0) k_send++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    check("stream_done", 64'(k_exp), 64'd11);
    check("stream_stalled", 64'(stalled), 64'd1);
    repeat (8) tick();

    put(32'd7, 1'b0);
    put(32'd9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", out_valid0, 64'd0);
    check("rst_mid_beats", out_beats0, 64'd0);
    put(32'd5, 1'b1);
    wait_out(lat);
    check("t6_latency", 64'(lat), 64'd6);
    check("t6_data",    out_data0,  64'd160);
    check("t6_beats",   out_beats0, 64'd1);
    tick();
    check("t6_no_stale", out_valid0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
